// File: rtl/reg_bus_arb.sv
// Two-master round-robin arbiter that sequences accesses to the reg_top port as SETUP -> ACCESS -> RESP.
// Optional lock-based re-grant is enabled with `define REG_ARB_LOCK_EN.
module reg_bus_arb #(
    parameter int AW     = 7,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          m0_req_i,
    input  logic          m0_wr_i,
    input  logic [AW-1:0] m0_address_i,
    input  logic [DW-1:0] m0_write_data_i,
    output logic          m0_ack_o,
    output logic [DW-1:0] m0_read_data_o,
`ifdef REG_ARB_LOCK_EN
    input  logic          m0_lock_i,
    input  logic          m1_lock_i,
`endif
    input  logic          m1_req_i,
    input  logic          m1_wr_i,
    input  logic [AW-1:0] m1_address_i,
    input  logic [DW-1:0] m1_write_data_i,
    output logic          m1_ack_o,
    output logic [DW-1:0] m1_read_data_o,
    output logic [1:0]    grant_o,
    output logic          busy_o,
    output logic          wr_o,
    output logic [AW-1:0] address_o,
    output logic          write_valid_o,
    output logic [DW-1:0] write_data_o,
    input  logic [DW-1:0] read_data_i
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [1:0] RD_CNT = RD_LAT[1:0];

    state_t     state;
    logic       last_grant;   // 1 = master 1 was granted last
    logic       owner;
    logic [1:0] cnt;
    logic       pick;
`ifdef REG_ARB_LOCK_EN
    logic       lock_hold;
`endif

    always_comb begin
        if (m0_req_i && m1_req_i) pick = ~last_grant;
        else                      pick = m1_req_i;
`ifdef REG_ARB_LOCK_EN
        if (lock_hold && (owner ? m1_req_i : m0_req_i)) pick = owner;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            cnt            <= '0;
            m0_ack_o       <= 1'b0;
            m1_ack_o       <= 1'b0;
            m0_read_data_o <= '0;
            m1_read_data_o <= '0;
            grant_o        <= '0;
            busy_o         <= 1'b0;
            wr_o           <= 1'b0;
            address_o      <= '0;
            write_valid_o  <= 1'b0;
            write_data_o   <= '0;
`ifdef REG_ARB_LOCK_EN
            lock_hold      <= 1'b0;
`endif
        end else begin
            write_valid_o <= 1'b0;
            m0_ack_o      <= 1'b0;
            m1_ack_o      <= 1'b0;
            case (state)
                IDLE: begin
`ifdef REG_ARB_LOCK_EN
                    lock_hold <= 1'b0;
`endif
                    if (m0_req_i || m1_req_i) begin
                        owner        <= pick;
                        last_grant   <= pick;
                        grant_o      <= pick ? 2'b10 : 2'b01;
                        wr_o         <= pick ? m1_wr_i : m0_wr_i;
                        address_o    <= pick ? m1_address_i : m0_address_i;
                        write_data_o <= pick ? m1_write_data_i : m0_write_data_i;
                        busy_o       <= 1'b1;
                        state        <= SETUP;
                    end
                end
                SETUP: begin
                    cnt           <= RD_CNT;
                    write_valid_o <= wr_o;
                    state         <= ACCESS;
                end
                ACCESS: begin
                    // Reads stay here RD_LAT+1 cycles; read data is captured on the last one.
                    if (wr_o || cnt == 2'd0) begin
                        state <= RESP;
                        if (owner) m1_ack_o <= 1'b1;
                        else       m0_ack_o <= 1'b1;
                        if (!wr_o) begin
                            if (owner) m1_read_data_o <= read_data_i;
                            else       m0_read_data_o <= read_data_i;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                RESP: begin
                    grant_o <= '0;
                    busy_o  <= 1'b0;
                    state   <= IDLE;
`ifdef REG_ARB_LOCK_EN
                    lock_hold <= owner ? (m1_lock_i && m1_req_i) : (m0_lock_i && m0_req_i);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
